// File: rtl/nibble_unloader.sv
// nibble_unloader: takes a 16-bit word on Start and presents it downstream
// as four 4-bit slots (slot 0 first) under a Valid/Ready handshake, then
// pulses Done for one cycle before returning to IDLE.
// Outputs are decoded from the state and holding registers only, so Ready
// never reaches an output combinationally.
module nibble_unloader (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    input  logic [15:0] Data,
    input  logic        Ready,
    output logic [3:0]  Nibble,
    output logic        Valid,
    output logic [3:0]  Select,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        SEND1 = 3'd2,
        SEND2 = 3'd3,
        SEND3 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_r;
    logic [15:0] hold_r;

    // State sequencing and word capture; unused encodings fall back to IDLE.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= IDLE;
            hold_r  <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        hold_r  <= Data;
                        state_r <= SEND0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND0: begin
                    if (Ready) begin
                        state_r <= SEND1;
                    end else begin
                        state_r <= SEND0;
                    end
                end
                SEND1: begin
                    if (Ready) begin
                        state_r <= SEND2;
                    end else begin
                        state_r <= SEND1;
                    end
                end
                SEND2: begin
                    if (Ready) begin
                        state_r <= SEND3;
                    end else begin
                        state_r <= SEND2;
                    end
                end
                SEND3: begin
                    if (Ready) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= SEND3;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output decode from state and held word; everything idles at zero.
    always_comb begin
        Nibble = 4'b0000;
        Valid  = 1'b0;
        Select = 4'b0000;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (state_r)
            SEND0: begin
                Nibble = hold_r[3:0];
                Select = 4'b0001;
                Valid  = 1'b1;
                Busy   = 1'b1;
            end
            SEND1: begin
                Nibble = hold_r[7:4];
                Select = 4'b0010;
                Valid  = 1'b1;
                Busy   = 1'b1;
            end
            SEND2: begin
                Nibble = hold_r[11:8];
                Select = 4'b0100;
                Valid  = 1'b1;
                Busy   = 1'b1;
            end
            SEND3: begin
                Nibble = hold_r[15:12];
                Select = 4'b1000;
                Valid  = 1'b1;
                Busy   = 1'b1;
            end
            DONE: begin
                Done = 1'b1;
            end
            default: begin
                Nibble = 4'b0000;
                Valid  = 1'b0;
                Select = 4'b0000;
                Busy   = 1'b0;
                Done   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_unloader.sv
// Scoreboard bench for nibble_unloader: a transaction-level model queues the
// expected slot stream for every accepted word; a monitor on the falling edge
// compares what the DUT presents against the queue head.
module tb_nibble_unloader;

    logic        Clock;
    logic        Resetn;
    logic        Start;
    logic [15:0] Data;
    logic        Ready;
    logic [3:0]  Nibble;
    logic        Valid;
    logic [3:0]  Select;
    logic        Busy;
    logic        Done;

    nibble_unloader dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start),
        .Data   (Data),
        .Ready  (Ready),
        .Nibble (Nibble),
        .Valid  (Valid),
        .Select (Select),
        .Busy   (Busy),
        .Done   (Done)
    );

    typedef struct {
        bit         is_done;
        logic [3:0] nib;
        logic [3:0] sel;
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    // Model view: number of slots still owed, and whether the Done cycle is pending.
    int    owed = 0;
    bit    done_pending = 1'b0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one word in flight at a time; a word occupies four
    // accepted slots plus one Done cycle, and only then can a new Start be taken.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q.delete();
            owed = 0;
            done_pending = 1'b0;
        end else if (done_pending) begin
            done_pending = 1'b0;
        end else if (owed > 0) begin
            if (Ready) begin
                owed = owed - 1;
                if (owed == 0) done_pending = 1'b1;
            end
        end else if (Start) begin
            for (int k = 0; k < 4; k++) begin
                item_t it;
                it.is_done = 1'b0;
                it.nib = Data[4*k +: 4];
                it.sel = 4'b0001 << k;
                q.push_back(it);
            end
            begin
                item_t d;
                d.is_done = 1'b1;
                d.nib = 4'b0000;
                d.sel = 4'b0000;
                q.push_back(d);
            end
            owed = 4;
        end
    end

    // Monitor: invariants every cycle, then compare against the queue head.
    always @(negedge Clock) begin
        chk("select_onehot", int'($countones(Select) <= 1), 1);
        chk("valid_eq_or_select", int'(Valid), int'(|Select));
        chk("done_not_busy", int'(Done && Busy), 0);
        if (!Resetn || q.size() == 0) begin
            chk("idle_valid", int'(Valid), 0);
            chk("idle_done", int'(Done), 0);
            chk("idle_busy", int'(Busy), 0);
            chk("idle_nibble", int'(Nibble), 0);
            chk("idle_select", int'(Select), 0);
        end else if (q[0].is_done) begin
            chk("done_pulse", int'(Done), 1);
            chk("done_valid", int'(Valid), 0);
            chk("done_busy", int'(Busy), 0);
            chk("done_select", int'(Select), 0);
            void'(q.pop_front());
        end else begin
            chk("send_valid", int'(Valid), 1);
            chk("send_busy", int'(Busy), 1);
            chk("send_done", int'(Done), 0);
            chk("send_nibble", int'(Nibble), int'(q[0].nib));
            chk("send_select", int'(Select), int'(q[0].sel));
            if (Ready) void'(q.pop_front());
        end
    end

    // Apply inputs, let one rising edge consume them, settle just after it.
    task automatic step(input logic s, input logic [15:0] d, input logic r);
        Start = s;
        Data  = d;
        Ready = r;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Resetn = 1'b0;
        Start  = 1'b0;
        Data   = 16'h0000;
        Ready  = 1'b0;
        #1;
        chk("reset_valid", int'(Valid), 0);
        chk("reset_select", int'(Select), 0);
        chk("reset_nibble", int'(Nibble), 0);
        chk("reset_busy_done", int'(Busy | Done), 0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        // Nominal word
        step(1'b1, 16'hA5C3, 1'b1);
        repeat (6) step(1'b0, 16'($urandom), 1'b1);

        // Backpressure: stall three cycles in SEND1
        step(1'b1, 16'h1234, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        repeat (3) step(1'b0, 16'($urandom), 1'b0);
        repeat (5) step(1'b0, 16'h0000, 1'b1);

        // Start/Data ignored in SEND2 and in DONE
        step(1'b1, 16'h6B2E, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'hFFFF, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'hFFFF, 1'b1);
        chk("idle_after_done", int'(Valid | Busy | Done), 0);
        repeat (2) step(1'b0, 16'h0000, 1'b1);

        // Reset in SEND2 between edges
        step(1'b1, 16'hABCD, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        chk("pre_reset_select", int'(Select), 4);
        #2;
        Resetn = 1'b0;
        #1;
        chk("async_reset_valid", int'(Valid), 0);
        chk("async_reset_select", int'(Select), 0);
        chk("async_reset_nibble", int'(Nibble), 0);
        chk("async_reset_busy", int'(Busy), 0);
        @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        Start  = 1'b1;
        Data   = 16'h0F0F;
        Ready  = 1'b1;
        @(posedge Clock);
        #1;
        repeat (6) step(1'b0, 16'h0000, 1'b1);

        // Back-to-back with Start held high and Data changing every cycle
        repeat (30) step(1'b1, 16'($urandom), 1'b1);
        repeat (6) step(1'b0, 16'h0000, 1'b1);

        // Random traffic
        repeat (400) step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 9) < 7);

        // Drain with a bounded wait
        Start = 1'b0;
        Ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge Clock);
        @(negedge Clock);
        #1;
        chk("drain_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/nibble_unloader.md
NIBBLE_UNLOADER -- requirements
Module: nibble_unloader

Interface
REQ-001 The block SHALL have no parameters; the slot count is fixed at 4 and the slot width at 4 bits.
REQ-002 Clock  input  1  single clock; all state changes occur on its rising edge.
REQ-003 Resetn  input  1  reset, asynchronous and active-low.
REQ-004 Start  input  1  request to unload one 16-bit word; sampled only in IDLE.
REQ-005 Data  input  16  word to unload; slot k = Data[4k+3:4k]; captured on the accepted Start edge.
REQ-006 Ready  input  1  downstream accepts the current nibble this cycle.
REQ-007 Nibble  output  4  current slot value; 4'b0000 when Valid=0.
REQ-008 Valid  output  1  Nibble and Select are meaningful.
REQ-009 Select  output  4  one-hot slot index (bit k for slot k); 4'b0000 when not sending.
REQ-010 Busy  output  1  high from the first send state through the last send state.
REQ-011 Done  output  1  one-cycle pulse after slot 3 is accepted.

Function
REQ-012 The FSM SHALL have 6 states: IDLE, SEND0, SEND1, SEND2, SEND3, DONE, held in a 3-bit state register.
REQ-013 All outputs SHALL be decoded combinationally from the state register and the captured word only, so Ready SHALL have no combinational path to any output.
REQ-014 In IDLE with Start=1 at a rising edge, the block SHALL capture Data into a 16-bit holding register and enter SEND0.
REQ-015 In IDLE with Start=0, the block SHALL remain in IDLE; the holding register SHALL retain its value.
REQ-016 In SENDk, the outputs SHALL be Valid=1, Busy=1, Select=one-hot bit k, and Nibble=holding[4k+3:4k].
REQ-017 In SENDk, the block SHALL advance on the rising edge where Ready=1: SENDk to SEND(k+1) for k<3, and SEND3 to DONE.
REQ-018 In SENDk with Ready=0, the block SHALL hold its state, and Nibble and Select SHALL stay stable.
REQ-019 In DONE, the outputs SHALL be Done=1, Valid=0, Busy=0, and Select=0000; DONE SHALL go unconditionally to IDLE on the next edge.
REQ-020 Start SHALL be ignored in every state except IDLE, including DONE; Data changes outside the capture edge SHALL have no effect.
REQ-021 With Ready held at 1, the latency SHALL be: Start edge n; SEND0..SEND3 visible after edges n..n+3; Done visible after edge n+4; IDLE after edge n+5.
REQ-022 The minimum issue interval SHALL be 6 cycles; back-to-back Start SHALL be accepted on the first edge after returning to IDLE.
REQ-023 The state register SHALL never hold an illegal encoding after reset; if it does, the next edge SHALL force IDLE.
REQ-024 At most one Select bit SHALL be high in any cycle; Valid SHALL equal the OR of the Select bits.

Reset
REQ-025 Resetn=0 SHALL immediately force IDLE without waiting for Clock, and clear the holding register to 16'h0000.
REQ-026 During and after reset, the outputs SHALL be Nibble=0000, Valid=0, Select=0000, Busy=0, Done=0.
REQ-027 A reset asserted mid-transfer SHALL abort the transfer with no Done pulse; after release the block SHALL wait in IDLE for a new Start.
REQ-028 Resetn deassertion SHALL be sampled on the next rising edge, and the first Start SHALL be accepted on that edge or later.

Verification
REQ-029 Nominal case: Data=16'hA5C3, Start pulse, Ready=1 -> Nibble 3,C,5,A with Select 0001,0010,0100,1000 on consecutive cycles, then Done=1 for one cycle, then IDLE.
REQ-030 Backpressure case: Data=16'h1234, Ready=0 for 3 cycles in SEND1 -> Nibble=3 and Select=0010 held stable for 3 cycles, then the sequence continues with 2, then 1.
REQ-031 Ignored Start and Data: Start=1 and Data=16'hFFFF during SEND2 and during DONE -> the original word completes unchanged and no new transfer begins until the next IDLE Start.
REQ-032 Reset mid-transfer: Resetn=0 in SEND2 between clock edges -> all outputs are 0 at once, no Done pulse, and a subsequent Start with 16'h0F0F yields F,0,F,0.
REQ-033 Back-to-back: Start held at 1 continuously with Ready=1 -> transfers begin every 6 cycles, and each transfer uses the Data present at its capture edge.
REQ-034 Assertion checks on every cycle: Select is one-hot or zero, Valid equals the OR of Select, and Done is never high while Busy is high.
